// File: rtl/uart_key_pkg.sv
// Shared definitions for the keypad-code serial link. The transmitter uses
// them now, and a future oversampling receiver will use them too.
package uart_key_pkg;

    // The state order matches the nibble receiver's encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int   DATA_W    = 4;
    localparam int   KEY_W     = 24;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width for values 0..n-1. It is never smaller than one bit,
    // so a count of one still gets a real register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer. It counts 0..CLKS_PER_BIT-1 while i_clear is low and
// wraps at the end of each bit. o_bit_tick marks the last clock of a bit.
// o_pre_tick marks the clock before that one. It can only assert when a bit
// lasts two or more clocks.
module uart_bit_timer
    import uart_key_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int               CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] PRE   = (CLKS_PER_BIT > 1) ? CNT_W'(CLKS_PER_BIT - 2) : '0;

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick     = (r_cnt == LAST);
    assign o_bit_tick = w_tick;
    assign o_pre_tick = (CLKS_PER_BIT > 1) && (r_cnt == PRE);

    // The count is held at zero while cleared and restarts after every bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_key_tx.sv
// Keypad-code serial transmitter. It takes a word over a valid/ready
// handshake and sends it as NIBBLES frames, most-significant nibble first.
// Each frame is a start bit (0), DATA_W data bits LSB first, and a stop bit
// (1). Frames run back-to-back, and the line idles high.
//
// Handshake: a word transfers on a rising edge where i_valid && o_ready.
// o_ready is high only in IDLE, so inputs are ignored for the whole word.
// The accepted word is copied into a local shift register, so later changes
// on the inputs cannot corrupt it.
module uart_key_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = 4,
    parameter int NIBBLES      = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    input  logic [DATA_W*NIBBLES-1:0] i_key_code,
    output logic                      o_ready,
    output logic                      o_tx_bit,
    output logic                      o_busy,
    output logic                      o_done
);

    import uart_key_pkg::state_t;
    import uart_key_pkg::IDLE;
    import uart_key_pkg::START;
    import uart_key_pkg::DATA;
    import uart_key_pkg::STOP;
    import uart_key_pkg::START_BIT;
    import uart_key_pkg::STOP_BIT;
    import uart_key_pkg::cnt_width;

    localparam int WORD_W = DATA_W * NIBBLES;
    localparam int TOP    = WORD_W - DATA_W;
    localparam int NIB_W  = cnt_width(NIBBLES);
    localparam int IDX_W  = cnt_width(DATA_W);

    state_t            r_state;
    logic              r_tx_bit;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [WORD_W-1:0] r_shreg;
    logic [NIB_W-1:0]  r_nibble_cnt;
    logic [IDX_W-1:0]  r_bit_idx;

    logic              w_bit_tick;
    logic              w_pre_tick;
    logic              w_timer_clear;
    logic              w_last_idx;
    logic              w_last_nibble;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_next_bit;

    // The timer stays at zero in IDLE, so every bit, including the first
    // start bit after acceptance, lasts exactly CLKS_PER_BIT clocks.
    assign w_timer_clear = (r_state == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timer_clear),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    assign w_last_idx    = (r_bit_idx == IDX_W'(DATA_W - 1));
    assign w_last_nibble = (r_nibble_cnt == NIB_W'(NIBBLES - 1));
    assign w_next_idx    = r_bit_idx + 1'b1;
    // The current nibble always sits in the top DATA_W bits of the shift register.
    assign w_next_bit    = r_shreg[TOP + int'(w_next_idx)];

    // Framing FSM. Every output is registered. o_done is scheduled one clock
    // early, so it is high during the last clock of the final stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tx_bit     <= STOP_BIT;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_shreg      <= '0;
            r_nibble_cnt <= '0;
            r_bit_idx    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx_bit <= STOP_BIT;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    if (i_valid && r_ready) begin
                        r_shreg      <= i_key_code;
                        r_nibble_cnt <= '0;
                        r_bit_idx    <= '0;
                        r_state      <= START;
                        r_tx_bit     <= START_BIT;
                        r_ready      <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_tx_bit  <= r_shreg[TOP];
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (w_last_idx) begin
                            r_state  <= STOP;
                            r_tx_bit <= STOP_BIT;
                            // A one-clock stop bit is already the final clock.
                            r_done   <= w_last_nibble && (CLKS_PER_BIT == 1);
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx_bit  <= w_next_bit;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        if (!w_last_nibble) begin
                            r_shreg      <= r_shreg << DATA_W;
                            r_nibble_cnt <= r_nibble_cnt + 1'b1;
                            r_state      <= START;
                            r_tx_bit     <= START_BIT;
                        end else begin
                            r_state  <= IDLE;
                            r_tx_bit <= STOP_BIT;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end else begin
                        r_done <= w_last_nibble && w_pre_tick;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_tx_bit <= STOP_BIT;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready  = r_ready;
    assign o_tx_bit = r_tx_bit;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_uart_key_tx.sv
// Bench for uart_key_tx. It uses two instances: one at one clock per bit and
// one at four clocks per bit. Each expected line/done sequence comes from the
// framing rules and is queued when a word is accepted. A monitor compares it
// every clock. A simple deframer also rebuilds each word and checks it when
// o_done pulses.
module tb_uart_key_tx;

    logic        clk;
    logic        rst;
    logic        v1, v4;
    logic [23:0] k1, k4;
    logic        rdy1, tx1, busy1, done1;
    logic        rdy4, tx4, busy4, done4;

    int checks   = 0;
    int failures = 0;

    // Expected per-cycle {done, line}.
    logic [1:0]  exp_q1[$];
    logic [1:0]  exp_q4[$];
    logic [23:0] word_q1[$];

    // Deframer state.
    int          rx_cnt;
    logic [3:0]  rx_nib;
    logic [23:0] rx_buf;

    uart_key_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (v1),
        .i_key_code (k1),
        .o_ready    (rdy1),
        .o_tx_bit   (tx1),
        .o_busy     (busy1),
        .o_done     (done1)
    );

    uart_key_tx #(.CLKS_PER_BIT(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (v4),
        .i_key_code (k4),
        .o_ready    (rdy4),
        .o_tx_bit   (tx4),
        .o_busy     (busy4),
        .o_done     (done4)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a word is NIBBLES frames, MS nibble first. Each frame
    // is 0, four data bits LSB first, then 1. Each bit lasts cpb clocks, and
    // done is high only on the very last clock.
    task automatic push_word(input int which, input logic [23:0] w);
        int   cpb;
        logic b;
        logic last;
        cpb = (which == 1) ? 1 : 4;
        for (int n = 0; n < 6; n++) begin
            for (int p = 0; p < 6; p++) begin
                if (p == 0)      b = 1'b0;
                else if (p == 5) b = 1'b1;
                else             b = w[(5 - n) * 4 + (p - 1)];
                for (int c = 0; c < cpb; c++) begin
                    last = (n == 5) && (p == 5) && (c == cpb - 1);
                    if (which == 1) exp_q1.push_back({last, b});
                    else            exp_q4.push_back({last, b});
                end
            end
        end
        if (which == 1) word_q1.push_back(w);
    endtask

    // Driver: offer a word and wait (bounded) until ready is seen before an
    // edge. Then record the expectation after that edge.
    task automatic send(input int which, input logic [23:0] w, input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        if (which == 1) begin v1 = 1'b1; k1 = w; end
        else            begin v4 = 1'b1; k4 = w; end
        while (((which == 1) ? rdy1 : rdy4) !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (((which == 1) ? rdy1 : rdy4) !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout dut%0d actual=0 required=1", which);
            if (which == 1) v1 = 1'b0; else v4 = 1'b0;
            return;
        end
        @(posedge clk);
        push_word(which, w);
        @(negedge clk);
        if (!keep) begin
            if (which == 1) begin v1 = 1'b0; k1 = 24'($urandom); end
            else            begin v4 = 1'b0; k4 = 24'($urandom); end
        end
    endtask

    // Monitor / scoreboard for dut1, plus the deframer
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            rx_cnt = 0;
            rx_buf = '0;
        end else begin
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("tx1_line", 32'(tx1), 32'(e[0]));
                check("tx1_done", 32'(done1), 32'(e[1]));
                check("tx1_busy", 32'(busy1), 32'd1);
                check("tx1_ready", 32'(rdy1), 32'd0);
            end else begin
                check("tx1_idle_line", 32'(tx1), 32'd1);
                check("tx1_idle_done", 32'(done1), 32'd0);
                check("tx1_idle_busy", 32'(busy1), 32'd0);
                check("tx1_idle_ready", 32'(rdy1), 32'd1);
            end
            if (rx_cnt == 0) begin
                if (tx1 == 1'b0) rx_cnt = 1;
            end else if (rx_cnt <= 4) begin
                rx_nib[rx_cnt - 1] = tx1;
                rx_cnt++;
            end else begin
                rx_buf = {rx_buf[19:0], rx_nib};
                rx_cnt = 0;
            end
            if (done1 === 1'b1) begin
                if (word_q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_word_unexpected actual=%0h required=none", rx_buf);
                end else begin
                    check("rx_word", 32'(rx_buf), 32'(word_q1.pop_front()));
                end
            end
        end
    end

    // Monitor / scoreboard for dut4
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst) begin
            if (exp_q4.size() > 0) begin
                e = exp_q4.pop_front();
                check("tx4_line", 32'(tx4), 32'(e[0]));
                check("tx4_done", 32'(done4), 32'(e[1]));
                check("tx4_busy", 32'(busy4), 32'd1);
            end else begin
                check("tx4_idle_line", 32'(tx4), 32'd1);
                check("tx4_idle_done", 32'(done4), 32'd0);
                check("tx4_idle_ready", 32'(rdy4), 32'd1);
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        rst = 1'b1;
        v1  = 1'b0;
        v4  = 1'b0;
        k1  = '0;
        k4  = '0;
        #1;
        check("reset_tx", 32'(tx1), 32'd1);
        check("reset_ready", 32'(rdy1), 32'd1);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_done", 32'(done1), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Idle line after reset, with no valid
        repeat (100) @(negedge clk);

        // Directed words, including the all-zero and all-one patterns
        send(1, 24'h123456, 1'b0);
        send(1, 24'hA5F03C, 1'b0);
        send(1, 24'h000000, 1'b0);
        send(1, 24'hFFFFFF, 1'b0);

        // Valid held high, input changed mid-word, second word back-to-back
        send(1, 24'h111111, 1'b1);
        repeat (4) @(negedge clk);
        k1 = 24'h222222;
        send(1, 24'h222222, 1'b0);

        // Reset during nibble 3, data bit 2
        send(1, 24'h9C3E71, 1'b0);
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_tx", 32'(tx1), 32'd1);
        check("midreset_ready", 32'(rdy1), 32'd1);
        check("midreset_busy", 32'(busy1), 32'd0);
        check("midreset_done", 32'(done1), 32'd0);
        exp_q1.delete();
        word_q1.delete();
        exp_q4.delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        send(1, 24'h0000FF, 1'b0);

        // Slow instance, then random traffic on both instances in parallel
        send(4, 24'h800001, 1'b0);
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(1, 24'($urandom), ($urandom_range(0, 3) == 0));
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    send(4, 24'($urandom), 1'b0);
                end
            end
        join
        v1 = 1'b0;
        v4 = 1'b0;

        // Drain, with a bound
        t = 0;
        while ((exp_q1.size() > 0 || exp_q4.size() > 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_q1_empty", 32'(exp_q1.size()), 32'd0);
        check("drain_q4_empty", 32'(exp_q4.size()), 32'd0);
        check("drain_words_empty", 32'(word_q1.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_key_tx.md
Name: uart_key_tx

Overview:
Serial transmitter that feeds the keypad-code nibble receiver. It accepts a 24-bit key code over a valid/ready handshake and serializes it as six 4-bit frames, most-significant nibble first. Each frame is a start bit (0), four data bits LSB first, and a stop bit (1); the line idles high. Because the receiver shifts each new nibble into the LSB of its 24-bit buffer, this nibble order reconstructs the word unchanged at the far end.

Parameters:
CLKS_PER_BIT, 1, clk cycles per serial bit (>=1); 1 matches the receiver's one-bit-per-clock sampling.
DATA_W, 4, data bits per frame.
NIBBLES, 6, frames per word; word width = DATA_W*NIBBLES = 24.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
i_valid  input  1  key code on i_key_code is valid
i_key_code  input  24  word to send; bits [23:20] go first
o_ready  output  1  high only in IDLE; a transfer occurs when i_valid && o_ready
o_tx_bit  output  1  serial line, registered, idle 1
o_busy  output  1  high from the cycle after acceptance until the last stop bit completes
o_done  output  1  one-cycle pulse in the final cycle of the last stop bit

Behaviour:
- Reset values (asynchronous): state=IDLE, o_tx_bit=1, o_ready=1, o_busy=0, o_done=0, all counters 0, shift register 0.
- States: IDLE, START, DATA, STOP. The bit timer counts 0..CLKS_PER_BIT-1, is $clog2-sized with a minimum of 1 bit, and each state holds for exactly CLKS_PER_BIT cycles per bit.
- IDLE: o_tx_bit=1. On i_valid && o_ready at edge T, i_key_code is latched into a 24-bit shift register, the nibble counter is set to 0, and the state moves to START. o_tx_bit=0 is visible from T+1, so latency is 1 cycle.
- START: drives 0 for one bit time, then moves to DATA with the bit index at 0.
- DATA: drives shreg[20+idx] for idx 0..3, one bit time each. After idx 3 it moves to STOP.
- STOP: drives 1 for one bit time. At the end:
  - If nibble_cnt < NIBBLES-1: shift the register left by 4, increment nibble_cnt, go to START. Frames are back-to-back with no idle gap.
  - Otherwise: assert o_done for that final stop cycle and go to IDLE. o_ready rises the following cycle.
- Word duration is NIBBLES*(DATA_W+2)*CLKS_PER_BIT cycles: 36 at the defaults.
- i_valid and i_key_code are ignored while not in IDLE. The latched copy is unaffected by input changes mid-word.
- A new word accepted in the cycle o_ready returns starts immediately. Minimum inter-word gap is 1 idle-high cycle.
- rst mid-word: the line goes to 1 immediately, the word is abandoned, and no o_done is issued. The partial frame is the receiver's problem; its STOP state resyncs on the next start bit.
- The default state encoding decodes to IDLE with o_tx_bit=1.

Decomposition:
- Shared package uart_key_pkg: state enum (IDLE/START/DATA/STOP = 2'd0..3, in the receiver's encoding order), DATA_W=4, KEY_W=24, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module uart_bit_timer: parameterized CLKS_PER_BIT counter with a clear input and a bit_tick output. It is shared with a future oversampling receiver. Everything else stays in one module.

Test Plan:
1. CLKS_PER_BIT=1, one-cycle valid with 0x123456 -> o_tx_bit sequence from T+1: 0,1,0,0,0,1 | 0,0,1,0,0,1 | 0,1,1,0,0,1 | 0,0,0,1,0,1 | 0,1,0,1,0,1 | 0,0,1,1,0,1. o_done pulses in cycle T+36; o_ready is high in T+37.
2. Loopback into the existing nibble receiver with 0xA5F03C -> receiver key_buf_code_1 == 0xA5F03C after the last stop. Repeat with 0x000000 and 0xFFFFFF.
3. i_valid held high with 0x111111 then 0x222222 (input changed at T+5) -> the first word is sent intact, the second is accepted the cycle o_ready rises, and exactly 1 idle-high cycle separates them.
4. Assert rst during nibble 3, data bit 2 -> o_tx_bit=1 and o_ready=1 in the same cycle, no o_done. A subsequent 0x0000FF is sent correctly.
5. CLKS_PER_BIT=4, send 0x800001 -> each bit is held exactly 4 cycles, total 144 cycles, first frame 0,0,0,0,1,1 (each x4).
6. Idle checks: with no valid, o_tx_bit stays 1, o_busy stays 0, and o_done never asserts over 100 cycles after reset release.
